// File: rtl/jelly_credit_counter.sv
// ---------------------------------------------------------------------------
// jelly_credit_counter
//
// Purpose:
//   Credit counter for the command issuer. Every clock edge it adds the
//   released credit (when add_valid) and subtracts the consumed credit
//   (when sub_valid). Arithmetic is modulo 2^COUNTER_WIDTH. A carry out of
//   the add stage sets a sticky overflow flag that only reset clears.
//
// Ports:
//   aclk          in   clock
//   aresetn       in   asynchronous active-low reset
//   add           in   credits returned
//   add_valid     in   qualifier for add
//   sub           in   credits consumed
//   sub_valid     in   qualifier for sub
//   counter       out  current credit (registered)
//   empty         out  counter == 0 (registered)
//   err_overflow  out  sticky overflow flag
// ---------------------------------------------------------------------------
module jelly_credit_counter #(
  parameter int COUNTER_WIDTH = 9,
  parameter int INIT_COUNTER  = 256
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [COUNTER_WIDTH-1:0] add,
  input  logic                     add_valid,
  input  logic [COUNTER_WIDTH-1:0] sub,
  input  logic                     sub_valid,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     empty,
  output logic                     err_overflow
);

  localparam logic [COUNTER_WIDTH-1:0] ZERO     = '0;
  localparam logic [COUNTER_WIDTH-1:0] INIT_VAL = COUNTER_WIDTH'(INIT_COUNTER);

  logic [COUNTER_WIDTH-1:0] r_counter;
  logic                     r_empty;
  logic                     r_overflow;

  logic [COUNTER_WIDTH:0]   w_sum;
  logic [COUNTER_WIDTH-1:0] w_next;

  // The add stage is one bit wider so its carry reveals overflow; the
  // subtraction then works on the wrapped sum.
  always_comb begin
    w_sum  = {1'b0, r_counter} + {1'b0, (add_valid ? add : ZERO)};
    w_next = w_sum[COUNTER_WIDTH-1:0] - (sub_valid ? sub : ZERO);
  end

  // Counter and empty flag are both loaded from the same next value so
  // they never disagree.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_counter  <= INIT_VAL;
      r_empty    <= (INIT_VAL == ZERO);
      r_overflow <= 1'b0;
    end else begin
      r_counter <= w_next;
      r_empty   <= (w_next == ZERO);
      if (w_sum[COUNTER_WIDTH]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign counter      = r_counter;
  assign empty        = r_empty;
  assign err_overflow = r_overflow;

endmodule

// File: rtl/jelly_credit_cmd_issuer.sv
// ---------------------------------------------------------------------------
// jelly_credit_cmd_issuer
//
// Purpose:
//   Forwards a command (payload + length) only when enough credit is
//   available. Each accepted command debits len+1 credits; the consumer
//   returns credits through rel_add/rel_valid. Output is a single register
//   stage with valid/ready handshake.
//
// Ports:
//   aclk            in   clock
//   aresetn         in   asynchronous active-low reset
//   rel_add         in   credits returned
//   rel_valid       in   rel_add qualifier (always accepted)
//   s_data          in   command payload
//   s_len           in   command length, needs s_len+1 credits
//   s_valid         in   command valid
//   s_ready         out  command accepted when s_valid && s_ready
//   m_data          out  issued payload
//   m_len           out  issued length
//   m_valid         out  issued command valid
//   m_ready         in   downstream ready
//   credit_counter  out  current credit (registered)
//   credit_empty    out  credit_counter == 0 (registered)
//   err_overflow    out  sticky credit overflow flag
// ---------------------------------------------------------------------------
module jelly_credit_cmd_issuer #(
  parameter int COUNTER_WIDTH = 9,
  parameter int INIT_COUNTER  = 256,
  parameter int LEN_WIDTH     = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [COUNTER_WIDTH-1:0] rel_add,
  input  logic                     rel_valid,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic [LEN_WIDTH-1:0]     s_len,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [LEN_WIDTH-1:0]     m_len,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [COUNTER_WIDTH-1:0] credit_counter,
  output logic                     credit_empty,
  output logic                     err_overflow
);

  localparam int                     NEED_WIDTH = COUNTER_WIDTH;
  localparam logic [NEED_WIDTH-1:0]  NEED_ONE   = NEED_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  DATA_ZERO  = '0;
  localparam logic [LEN_WIDTH-1:0]   LEN_ZERO   = '0;

  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [LEN_WIDTH-1:0]  r_m_len;

  logic [NEED_WIDTH-1:0] w_need;
  logic                  w_ready;
  logic                  w_accept;
  logic [NEED_WIDTH-1:0] w_credit;

  // The need is zero-extended before the +1 so len = max gives
  // 2^LEN_WIDTH without wrapping. Only registered credit is compared, so
  // a release in this cycle cannot help this cycle's command.
  always_comb begin
    w_need   = {{(NEED_WIDTH-LEN_WIDTH){1'b0}}, s_len} + NEED_ONE;
    w_ready  = (!r_m_valid || m_ready) && (w_credit >= w_need);
    w_accept = s_valid && w_ready;
  end

  jelly_credit_counter #(
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .INIT_COUNTER  (INIT_COUNTER)
  ) u_counter (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .add          (rel_add),
    .add_valid    (rel_valid),
    .sub          (w_need),
    .sub_valid    (w_accept),
    .counter      (w_credit),
    .empty        (credit_empty),
    .err_overflow (err_overflow)
  );

  // Output register: loads on accept, clears when drained without a
  // replacement, otherwise holds so the payload stays stable under stall.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= DATA_ZERO;
      r_m_len   <= LEN_ZERO;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= s_data;
      r_m_len   <= s_len;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready        = w_ready;
  assign m_valid        = r_m_valid;
  assign m_data         = r_m_data;
  assign m_len          = r_m_len;
  assign credit_counter = w_credit;

endmodule

// File: tb/tb_jelly_credit_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_jelly_credit_cmd_issuer
//
// Purpose:
//   Self-checking bench for jelly_credit_cmd_issuer with INIT_COUNTER=16.
//   A vector table covers issue, credit exhaustion, release timing,
//   simultaneous release/accept and the maximum-length command; hand
//   sequences cover downstream stall, overflow and async reset.
// ---------------------------------------------------------------------------
module tb_jelly_credit_cmd_issuer;

  localparam int CW   = 9;
  localparam int LW   = 8;
  localparam int DW   = 32;
  localparam int INIT = 16;

  logic          aclk;
  logic          aresetn;
  logic [CW-1:0] rel_add;
  logic          rel_valid;
  logic [DW-1:0] s_data;
  logic [LW-1:0] s_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_len;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] credit_counter;
  logic          credit_empty;
  logic          err_overflow;

  int testsRun;
  int testsFailed;

  jelly_credit_cmd_issuer #(
    .COUNTER_WIDTH (CW),
    .INIT_COUNTER  (INIT),
    .LEN_WIDTH     (LW),
    .DATA_WIDTH    (DW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .rel_add        (rel_add),
    .rel_valid      (rel_valid),
    .s_data         (s_data),
    .s_len          (s_len),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_len          (m_len),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .credit_counter (credit_counter),
    .credit_empty   (credit_empty),
    .err_overflow   (err_overflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [CW-1:0] relAdd;
    logic          relValid;
    logic [LW-1:0] sLen;
    logic          sValid;
    logic [DW-1:0] sData;
    logic          mReady;
    logic          expReady;
    logic [CW-1:0] expCredit;
    logic          expEmpty;
    logic          expValid;
    logic [DW-1:0] expData;
    logic [LW-1:0] expLen;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, checks s_ready before the edge and the
  // registered outputs just after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    rel_add   = v.relAdd;
    rel_valid = v.relValid;
    s_len     = v.sLen;
    s_valid   = v.sValid;
    s_data    = v.sData;
    m_ready   = v.mReady;
    #2;
    checkOutput($sformatf("v%0d s_ready", idx), 64'(s_ready), 64'(v.expReady));
    @(posedge aclk);
    #1;
    checkOutput($sformatf("v%0d credit", idx), 64'(credit_counter), 64'(v.expCredit));
    checkOutput($sformatf("v%0d empty", idx), 64'(credit_empty), 64'(v.expEmpty));
    checkOutput($sformatf("v%0d m_valid", idx), 64'(m_valid), 64'(v.expValid));
    checkOutput($sformatf("v%0d m_data", idx), 64'(m_data), 64'(v.expData));
    checkOutput($sformatf("v%0d m_len", idx), 64'(m_len), 64'(v.expLen));
  endtask

  task automatic idleInputs();
    rel_add   = '0;
    rel_valid = 1'b0;
    s_len     = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
  endtask

  task automatic doReset();
    idleInputs();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " credit"}, 64'(credit_counter), 64'(INIT));
    checkOutput({tag, " empty"}, 64'(credit_empty), 64'(0));
    checkOutput({tag, " m_valid"}, 64'(m_valid), 64'(0));
    checkOutput({tag, " m_data"}, 64'(m_data), 64'(0));
    checkOutput({tag, " m_len"}, 64'(m_len), 64'(0));
    checkOutput({tag, " err"}, 64'(err_overflow), 64'(0));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    //            relAdd rv  len   sv  data          mr  rdy  cred emp val data          len
    vecs[0]  = '{9'd0,   0, 8'd3,   1, 32'hA0,       1,  1,  9'd12, 0, 1, 32'hA0,  8'd3};
    vecs[1]  = '{9'd0,   0, 8'd3,   1, 32'hA1,       1,  1,  9'd8,  0, 1, 32'hA1,  8'd3};
    vecs[2]  = '{9'd0,   0, 8'd3,   1, 32'hA2,       1,  1,  9'd4,  0, 1, 32'hA2,  8'd3};
    vecs[3]  = '{9'd0,   0, 8'd3,   1, 32'hA3,       1,  1,  9'd0,  1, 1, 32'hA3,  8'd3};
    vecs[4]  = '{9'd0,   0, 8'd3,   1, 32'hA4,       1,  0,  9'd0,  1, 0, 32'hA3,  8'd3};
    vecs[5]  = '{9'd4,   1, 8'd3,   1, 32'hA5,       1,  0,  9'd4,  0, 0, 32'hA3,  8'd3};
    vecs[6]  = '{9'd0,   0, 8'd3,   1, 32'hA5,       1,  1,  9'd0,  1, 1, 32'hA5,  8'd3};
    vecs[7]  = '{9'd6,   1, 8'd3,   0, 32'hA7,       1,  0,  9'd6,  0, 0, 32'hA5,  8'd3};
    vecs[8]  = '{9'd2,   1, 8'd3,   1, 32'hA8,       1,  1,  9'd4,  0, 1, 32'hA8,  8'd3};
    vecs[9]  = '{9'd252, 1, 8'd255, 1, 32'hA9,       1,  0,  9'd256,0, 0, 32'hA8,  8'd3};
    vecs[10] = '{9'd0,   0, 8'd255, 1, 32'hAA,       1,  1,  9'd0,  1, 1, 32'hAA,  8'd255};

    doReset();
    checkResetState("reset1");
    s_len = 8'd3;
    #1;
    checkOutput("reset1 s_ready len3", 64'(s_ready), 64'(1));
    @(posedge aclk);
    #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Downstream stall: command held stable, no further accept.
    doReset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_len   = 8'd3;
    s_data  = 32'hB0;
    #1;
    checkOutput("stall first s_ready", 64'(s_ready), 64'(1));
    @(posedge aclk);
    #1;
    checkOutput("stall first credit", 64'(credit_counter), 64'(12));
    s_data = 32'hB1;
    s_len  = 8'd1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checkOutput($sformatf("stall c%0d s_ready", c), 64'(s_ready), 64'(0));
      @(posedge aclk);
      #1;
      checkOutput($sformatf("stall c%0d m_valid", c), 64'(m_valid), 64'(1));
      checkOutput($sformatf("stall c%0d m_data", c), 64'(m_data), 64'(32'hB0));
      checkOutput($sformatf("stall c%0d m_len", c), 64'(m_len), 64'(3));
      checkOutput($sformatf("stall c%0d credit", c), 64'(credit_counter), 64'(12));
    end
    m_ready = 1'b1;
    #1;
    checkOutput("drain s_ready", 64'(s_ready), 64'(1));
    @(posedge aclk);
    #1;
    checkOutput("drain m_data", 64'(m_data), 64'(32'hB1));
    checkOutput("drain m_len", 64'(m_len), 64'(1));
    checkOutput("drain credit", 64'(credit_counter), 64'(10));
    s_valid = 1'b0;
    @(posedge aclk);
    #1;
    checkOutput("drain m_valid clear", 64'(m_valid), 64'(0));

    // Overflow: reach 510, then add 5 to wrap to 3.
    doReset();
    rel_valid = 1'b1;
    rel_add   = 9'd494;
    @(posedge aclk);
    #1;
    checkOutput("ovf pre credit", 64'(credit_counter), 64'(510));
    checkOutput("ovf pre err", 64'(err_overflow), 64'(0));
    rel_add = 9'd5;
    @(posedge aclk);
    #1;
    checkOutput("ovf credit wrap", 64'(credit_counter), 64'(3));
    checkOutput("ovf err set", 64'(err_overflow), 64'(1));
    rel_valid = 1'b0;
    rel_add   = '0;
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_len     = 8'd1;
    s_data    = 32'hC0;
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    checkOutput("ovf err sticky", 64'(err_overflow), 64'(1));
    checkOutput("ovf accept credit", 64'(credit_counter), 64'(1));
    checkOutput("ovf accept m_valid", 64'(m_valid), 64'(1));
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("ovf err sticky later", 64'(err_overflow), 64'(1));

    // Async reset between edges clears everything immediately.
    #2;
    aresetn = 1'b0;
    #1;
    checkResetState("async");
    #1;
    aresetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
